// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register-file slaves (write and read channels).
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_W  = 3'd1,
        WAIT_AW = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } wr_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_lite_wr_slave.sv
// AXI4-Lite write slave: latches AW/W in any order, issues one byte-enabled register write, answers on B.
// Latency: final AW/W handshake in cycle N -> reg_wr_en in N+1 -> bvalid in N+2.
// Backpressure: one transaction in flight; awready/wready stay low until the B handshake completes.
module axi_lite_wr_slave
    import axi_lite_pkg::*;
#(
    parameter int C_ADDR_WIDTH   = 10,
    parameter int C_DATA_WIDTH   = 32,
    parameter int C_NUM_REGS     = 64,
    parameter int C_ERR_ON_RANGE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [C_ADDR_WIDTH-1:0]   awaddr,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [C_DATA_WIDTH-1:0]   wdata,
    input  logic [C_DATA_WIDTH/8-1:0] wstrb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    output logic [C_ADDR_WIDTH-1:0]   reg_wr_addr,
    output logic                      reg_wr_en,
    output logic [C_DATA_WIDTH-1:0]   reg_wr_data,
    output logic [C_DATA_WIDTH/8-1:0] reg_wr_be
);

    localparam int STRB_W   = C_DATA_WIDTH / 8;
    localparam int ADDR_LSB = clog2(STRB_W);
    localparam logic [C_ADDR_WIDTH-1:0] ADDR_MASK = ~C_ADDR_WIDTH'((1 << ADDR_LSB) - 1);
    localparam logic [31:0] NUM_REGS = 32'(C_NUM_REGS);

    wr_state_t               state;
    wr_state_t               state_nxt;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [C_DATA_WIDTH-1:0] data_q;
    logic [STRB_W-1:0]       strb_q;
    logic [1:0]              bresp_q;
    logic                    aw_hs;
    logic                    w_hs;
    logic [31:0]             word_idx;
    logic                    in_range;
    logic                    do_write;

    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign word_idx = 32'(addr_q >> ADDR_LSB);
    assign in_range = (word_idx < NUM_REGS);
    assign do_write = in_range && (strb_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (aw_hs && w_hs) state_nxt = WRITE;
                else if (aw_hs)    state_nxt = WAIT_W;
                else if (w_hs)     state_nxt = WAIT_AW;
            end
            WAIT_W:  if (w_hs)   state_nxt = WRITE;
            WAIT_AW: if (aw_hs)  state_nxt = WRITE;
            WRITE:               state_nxt = RESP;
            RESP:    if (bready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Handshakes only occur in accepting states, so latching on them needs no state qualifier.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                addr_q <= awaddr;
            end
            if (w_hs) begin
                data_q <= wdata;
                strb_q <= wstrb;
            end
            if (state == WRITE) begin
                bresp_q <= (!in_range && (C_ERR_ON_RANGE != 0)) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_comb begin
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        reg_wr_en = 1'b0;
        case (state)
            IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
            end
            WAIT_W:  wready    = 1'b1;
            WAIT_AW: awready   = 1'b1;
            WRITE:   reg_wr_en = do_write;
            RESP:    bvalid    = 1'b1;
            default: ;
        endcase
        // A reset landing in the WRITE cycle must also kill that cycle's pulse.
        if (reset) begin
            awready   = 1'b0;
            wready    = 1'b0;
            reg_wr_en = 1'b0;
        end
    end

    assign bresp       = bresp_q;
    assign reg_wr_addr = addr_q & ADDR_MASK;
    assign reg_wr_data = data_q;
    assign reg_wr_be   = strb_q;

endmodule
